calc_display_ctrl: RTL and testbench

CALC_DISPLAY_CTRL -- requirements
Module: calc_display_ctrl

---
 rtl/calc_display_ctrl_if.sv | 16 +
 rtl/calc_display_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_calc_display_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_display_ctrl_if.sv
// Operand/handshake bundle for calc_display_ctrl.
// The master drives operands and the go strobe; the slave returns busy, the result and overflow.
interface calc_display_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         opp;
  logic               go;
  logic               busy;
  logic [2*WIDTH-1:0] result_o;
  logic               ovf_o;

  modport master (output a, b, opp, go, input busy, result_o, ovf_o);
  modport slave  (input a, b, opp, go, output busy, result_o, ovf_o);
endinterface

// File: rtl/calc_display_ctrl.sv
// Small ALU whose result is converted to BCD by sequential double dabble and shown on a
// multiplexed seven-segment display. Define CALC_SIGNED_SUB_EN to show a-b as a signed value.
module calc_display_ctrl #(
  parameter int WIDTH       = 4,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  calc_display_ctrl_if.slave bus,
  output logic [DIGITS-1:0] sseg_a_o,
  output logic [6:0]        sseg_c_o
);
  localparam int RW   = 2 * WIDTH;
  localparam int NBCD = (RW * 30103) / 100000 + 1;
  localparam int PAD  = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int CW   = $clog2(RW + 1);
  localparam logic [3:0] DASH = 4'hF;

  typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_e;

  state_e                 state_q;
  logic                   armed_q;
  logic                   busy_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic [2:0]             opp_q;
  logic [RW-1:0]          bin_q;
  logic [RW-1:0]          shift_q;
  logic [4*NBCD-1:0]      bcd_q;
  logic [CW-1:0]          cnt_q;
  logic [RW-1:0]          result_q;
  logic                   ovf_q;
  logic [3:0]             disp_q [DIGITS];
  logic [REFRESH_DIV-1:0] refresh_q;

  logic [RW-1:0]          aExt;
  logic [RW-1:0]          bExt;
  logic [RW-1:0]          alu;
  logic [RW-1:0]          aluMag;
  logic                   neg_q;
  logic [4*NBCD-1:0]      bcdAdj;
  logic [4*NBCD-1:0]      bcdNext;
  logic [4*PAD-1:0]       bcdPad;
  logic                   ovfNext;
  logic [3:0]             dispNext [DIGITS];
  logic [3:0]             scanIdx;
  logic [3:0]             shown;

  always_comb begin
    aExt = RW'(a_q);
    bExt = RW'(b_q);
    case (opp_q)
      3'b000:  alu = aExt + bExt;
      3'b001:  alu = aExt - bExt;
      3'b010:  alu = aExt * bExt;
      3'b011:  alu = aExt & bExt;
      3'b100:  alu = aExt | bExt;
      3'b101:  alu = aExt ^ bExt;
      3'b110:  alu = (aExt > bExt) ? aExt : bExt;
      default: alu = aExt;
    endcase
  end

`ifdef CALC_SIGNED_SUB_EN
  logic aluNeg;

  // Only subtraction is treated as signed; its magnitude feeds the BCD converter.
  assign aluNeg = (opp_q == 3'b001) && alu[RW-1];
  assign aluMag = aluNeg ? (RW'(0) - alu) : alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (state_q == CALC) begin
      neg_q <= aluNeg;
    end
  end
`else
  assign aluMag = alu;
  assign neg_q  = 1'b0;
`endif

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcdNext = (bcdAdj << 1) | {{(4*NBCD-1){1'b0}}, shift_q[RW-1]};
  end

  always_comb begin
    bcdPad = '0;
    bcdPad[4*NBCD-1:0] = bcd_q;
    ovfNext = 1'b0;
    for (int i = 0; i < PAD; i++) begin
      if ((i >= DIGITS || (neg_q && i >= DIGITS - 1)) && bcdPad[4*i +: 4] != 4'd0) begin
        ovfNext = 1'b1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      dispNext[i] = ovfNext ? DASH : bcdPad[4*i +: 4];
    end
    if (neg_q && !ovfNext) begin
      dispNext[DIGITS-1] = DASH;
    end
  end

  // Main sequencer; the visible result, overflow and digits only ever change together in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      opp_q    <= '0;
      bin_q    <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        disp_q[i] <= 4'd0;
      end
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.go && armed_q) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            opp_q   <= bus.opp;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          bin_q   <= alu;
          shift_q <= aluMag;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          bcd_q   <= bcdNext;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(RW - 1)) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          result_q <= bin_q;
          ovf_q    <= ovfNext;
          disp_q   <= dispNext;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
    end else begin
      refresh_q <= refresh_q + REFRESH_DIV'(1);
    end
  end

  // Scan position comes from the top three refresh bits folded onto the available digits.
  always_comb begin
    scanIdx  = {1'b0, refresh_q[REFRESH_DIV-1 -: 3]} % 4'(DIGITS);
    shown    = 4'd0;
    sseg_a_o = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scanIdx == 4'(i)) begin
        shown       = disp_q[i];
        sseg_a_o[i] = 1'b0;
      end
    end
  end

  always_comb begin
    case (shown)
      4'd0:    sseg_c_o = 7'b1000000;
      4'd1:    sseg_c_o = 7'b1111001;
      4'd2:    sseg_c_o = 7'b0100100;
      4'd3:    sseg_c_o = 7'b0110000;
      4'd4:    sseg_c_o = 7'b0011001;
      4'd5:    sseg_c_o = 7'b0010010;
      4'd6:    sseg_c_o = 7'b0000010;
      4'd7:    sseg_c_o = 7'b1111000;
      4'd8:    sseg_c_o = 7'b0000000;
      4'd9:    sseg_c_o = 7'b0010000;
      DASH:    sseg_c_o = 7'b0111111;
      default: sseg_c_o = 7'b1111111;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.result_o = result_q;
  assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_calc_display_ctrl.sv
// Randomised bench for calc_display_ctrl: two instances (4- and 8-bit operands) checked
// against an arithmetic reference model of results, overflow, digits and the scan pattern.
`timescale 1ns/1ps
module tb_calc_display_ctrl;
  localparam int DIGITS = 4;
  localparam int RDIV   = 5;
  localparam logic [6:0] SEG [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0111111};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_display_ctrl_if #(.WIDTH(4)) bus4 ();
  calc_display_ctrl_if #(.WIDTH(8)) bus8 ();
  logic [DIGITS-1:0] sa4, sa8;
  logic [6:0]        sc4, sc8;

  calc_display_ctrl #(.WIDTH(4), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .sseg_a_o(sa4), .sseg_c_o(sc4));
  calc_display_ctrl #(.WIDTH(8), .DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .sseg_a_o(sa8), .sseg_c_o(sc8));

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  longint     expRes [2];
  bit         expOvf [2];
  logic [6:0] expSeg [2][DIGITS];

  // Clocks elapsed since reset release, used to predict the scan position.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit getBusy(input int inst);
    return (inst != 0) ? bus8.busy : bus4.busy;
  endfunction

  function automatic longint getRes(input int inst);
    return (inst != 0) ? longint'(bus8.result_o) : longint'(bus4.result_o);
  endfunction

  function automatic bit getOvf(input int inst);
    return (inst != 0) ? bus8.ovf_o : bus4.ovf_o;
  endfunction

  function automatic logic [DIGITS-1:0] getAnode(input int inst);
    return (inst != 0) ? sa8 : sa4;
  endfunction

  function automatic logic [6:0] getCath(input int inst);
    return (inst != 0) ? sc8 : sc4;
  endfunction

  task automatic modelReset();
    for (int n = 0; n < 2; n++) begin
      expRes[n] = 0;
      expOvf[n] = 1'b0;
      for (int k = 0; k < DIGITS; k++) expSeg[n][k] = SEG[0];
    end
  endtask

  // Reference: plain integer arithmetic, then decimal digits by division.
  task automatic modelOp(input int inst, input int opp, input int a, input int b);
    int     w;
    longint modv, r, mag, lim, p;
    bit     neg;
    w    = (inst != 0) ? 8 : 4;
    modv = longint'(1) << (2 * w);
    neg  = 1'b0;
    case (opp)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = (a > b) ? a : b;
      default: r = a;
    endcase
    r   = ((r % modv) + modv) % modv;
    mag = r;
`ifdef CALC_SIGNED_SUB_EN
    if (opp == 1 && a < b) begin
      neg = 1'b1;
      mag = b - a;
    end
`endif
    lim = 1;
    for (int i = 0; i < (neg ? DIGITS - 1 : DIGITS); i++) lim = lim * 10;
    lim = lim - 1;
    expRes[inst] = r;
    expOvf[inst] = (mag > lim);
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      expSeg[inst][k] = expOvf[inst] ? SEG[10] : SEG[int'((mag / p) % 10)];
      p = p * 10;
    end
    if (neg && !expOvf[inst]) expSeg[inst][DIGITS-1] = SEG[10];
  endtask

  task automatic driveOps(input int inst, input int opp, input int a, input int b, input bit go);
    if (inst != 0) begin
      bus8.a = 8'(a); bus8.b = 8'(b); bus8.opp = 3'(opp); bus8.go = go;
    end else begin
      bus4.a = 4'(a); bus4.b = 4'(b); bus4.opp = 3'(opp); bus4.go = go;
    end
  endtask

  task automatic checkDisplay(input int inst);
    logic [DIGITS-1:0] want;
    int t;
    for (int k = 0; k < DIGITS; k++) begin
      want = ~(DIGITS'(1) << k);
      t = 0;
      while (getAnode(inst) !== want && t < 64) begin
        @(negedge clk);
        t++;
      end
      checkOutput("anode_reached", longint'(t < 64), 1);
      checkOutput("digit_seg", getCath(inst), expSeg[inst][k]);
    end
  endtask

  task automatic applyStimulus(input int inst, input int opp, input int a, input int b, input bit goMid);
    int     w, n;
    longint oldRes;
    w      = (inst != 0) ? 8 : 4;
    n      = 0;
    oldRes = expRes[inst];
    @(negedge clk);
    driveOps(inst, opp, a, b, 1'b1);
    @(negedge clk);
    driveOps(inst, int'($urandom_range(0, 7)), int'($urandom), int'($urandom), 1'b0);
    checkOutput("busy_start", getBusy(inst), 1);
    while (getBusy(inst) && n < 100) begin
      n++;
      checkOutput("hold_result", getRes(inst), oldRes);
      driveOps(inst, int'($urandom_range(0, 7)), int'($urandom), int'($urandom), goMid && n == 3);
      @(negedge clk);
    end
    driveOps(inst, 0, 0, 0, 1'b0);
    checkOutput("busy_cycles", n, 2 * w + 2);
    modelOp(inst, opp, a, b);
    checkOutput("result", getRes(inst), expRes[inst]);
    checkOutput("ovf", getOvf(inst), expOvf[inst]);
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_requeue", getBusy(inst), 0);
    end
    checkDisplay(inst);
  endtask

  initial begin
    logic [DIGITS-1:0] want;
    int idx, inst, w;
    driveOps(0, 0, 0, 0, 1'b0);
    driveOps(1, 0, 0, 0, 1'b0);
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy4", bus4.busy, 0);
    checkOutput("rst_busy8", bus8.busy, 0);
    checkOutput("rst_result4", getRes(0), 0);
    checkOutput("rst_ovf8", getOvf(1), 0);
    checkOutput("rst_anode", sa4, 4'b1110);
    checkOutput("rst_cathode", sc4, SEG[0]);

    rst = 1'b0;
    driveOps(0, 0, 1, 1, 1'b1);
    @(negedge clk);
    driveOps(0, 0, 0, 0, 1'b0);
    checkOutput("go_at_release_ignored", bus4.busy, 0);

    for (int i = 0; i < 40; i++) begin
      idx  = ((cyc / 4) % 8) % DIGITS;
      want = ~(DIGITS'(1) << idx);
      checkOutput("anode_scan", sa4, want);
      checkOutput("scan_cathode", sc4, expSeg[0][idx]);
      @(negedge clk);
    end

    applyStimulus(0, 0, 9, 7, 1'b0);
    applyStimulus(0, 2, 15, 15, 1'b1);
    applyStimulus(0, 1, 3, 5, 1'b0);
    applyStimulus(1, 2, 255, 255, 1'b0);
    applyStimulus(1, 1, 3, 5, 1'b0);
    applyStimulus(1, 0, 200, 100, 1'b0);

    for (int i = 0; i < 14; i++) begin
      inst = int'($urandom_range(0, 1));
      w    = (inst != 0) ? 8 : 4;
      applyStimulus(inst, int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << w) - 1)),
                    int'($urandom_range(0, (1 << w) - 1)), 1'(($urandom & 3) == 0));
    end

    applyStimulus(0, 2, 13, 11, 1'b0);
    @(negedge clk);
    driveOps(0, 0, 9, 9, 1'b1);
    @(negedge clk);
    driveOps(0, 0, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("busy_before_abort", bus4.busy, 1);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("abort_busy", bus4.busy, 0);
    checkOutput("abort_result", getRes(0), 0);
    checkOutput("abort_ovf", getOvf(0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkDisplay(0);
    checkDisplay(1);
    applyStimulus(0, 0, 9, 9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
